// File: rtl/risc_v_id_ex_ctrl_pkg.sv
// Shared opcode, branch funct3 and bubble definitions for the ID/EX control slice.
// Imported by the ID/EX register top and by the branch unit.
package rv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    localparam logic [6:0] BUBBLE_OPCODE = 7'b0000000;
    localparam logic [4:0] BUBBLE_RD     = 5'd0;

    // Only these formats read rs2, so only they can create an rs2 load-use hazard.
    function automatic logic reads_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

    // Register-writing ALU formats; OP_I is kept here so the decode side shares one list.
    function automatic logic is_alu(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_I);
    endfunction

endpackage

// File: rtl/risc_v_id_ex_ctrl_branch_unit.sv
// EX-stage branch/jump resolver: compare on forwarded operands plus target selection.
// Purely combinational; a bubble in EX never redirects.
module rv_branch_unit
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            valid,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            taken,
    output logic [XLEN-1:0] pc_branch
);

    logic            cond;
    logic [XLEN-1:0] target;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (op1 == op2);
            F3_BNE:  cond = (op1 != op2);
            F3_BLT:  cond = ($signed(op1) <  $signed(op2));
            F3_BGE:  cond = ($signed(op1) >= $signed(op2));
            F3_BLTU: cond = (op1 <  op2);
            F3_BGEU: cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        taken  = 1'b0;
        target = pc + imm;
        if (valid) begin
            case (opcode)
                OP_BRANCH: taken = cond;
                OP_JAL:    taken = 1'b1;
                OP_JALR: begin
                    taken  = 1'b1;
                    target = (op1 + imm) & ~XLEN'(1);
                end
                default:   taken = 1'b0;
            endcase
        end
        pc_branch = taken ? target : pc + XLEN'(4);
    end

endmodule

// File: rtl/risc_v_id_ex_ctrl.sv
// ID/EX pipeline register with MEM/WB bypass, load-use stall, taken-branch squash
// and saturating stall/squash counters.
module risc_v_id_ex_ctrl
    import rv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int STALL_CW = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [XLEN-1:0]     PC_ID,
    input  logic [31:0]         INSTRUCTION_ID,
    input  logic [XLEN-1:0]     IMM_ID,
    input  logic [XLEN-1:0]     REG_DATA1_ID,
    input  logic [XLEN-1:0]     REG_DATA2_ID,
    input  logic [2:0]          FUNCT3_ID,
    input  logic [6:0]          FUNCT7_ID,
    input  logic [6:0]          OPCODE_ID,
    input  logic [4:0]          RD_ID,
    input  logic [4:0]          RS1_ID,
    input  logic [4:0]          RS2_ID,
    input  logic                RegWrite_MEM,
    input  logic [4:0]          RD_MEM,
    input  logic [XLEN-1:0]     ALU_DATA_MEM,
    input  logic                RegWrite_WB,
    input  logic [4:0]          RD_WB,
    input  logic [XLEN-1:0]     ALU_DATA_WB,
    output logic [XLEN-1:0]     PC_EX,
    output logic [XLEN-1:0]     IMM_EX,
    output logic [XLEN-1:0]     OP1_EX,
    output logic [XLEN-1:0]     OP2_EX,
    output logic [2:0]          FUNCT3_EX,
    output logic [6:0]          FUNCT7_EX,
    output logic [6:0]          OPCODE_EX,
    output logic [4:0]          RD_EX,
    output logic [4:0]          RS1_EX,
    output logic [4:0]          RS2_EX,
    output logic                VALID_EX,
    output logic                PCSrc,
    output logic [XLEN-1:0]     PC_Branch,
    output logic                PC_write,
    output logic                IF_ID_write,
    output logic [STALL_CW-1:0] STALL_COUNT,
    output logic [STALL_CW-1:0] SQUASH_COUNT
);

    logic [XLEN-1:0] data1_reg;
    logic [XLEN-1:0] data2_reg;
    logic            squash_pend_reg;
    logic            squash_active;
    logic            load_use;
    logic            bubble;
    logic            unused_instr;

    // The raw instruction is carried for debug visibility only.
    assign unused_instr = ^INSTRUCTION_ID;

    always_comb begin
        OP1_EX = data1_reg;
        if (RegWrite_MEM && RD_MEM != 5'd0 && RD_MEM == RS1_EX)
            OP1_EX = ALU_DATA_MEM;
        else if (RegWrite_WB && RD_WB != 5'd0 && RD_WB == RS1_EX)
            OP1_EX = ALU_DATA_WB;
    end

    always_comb begin
        OP2_EX = data2_reg;
        if (RegWrite_MEM && RD_MEM != 5'd0 && RD_MEM == RS2_EX)
            OP2_EX = ALU_DATA_MEM;
        else if (RegWrite_WB && RD_WB != 5'd0 && RD_WB == RS2_EX)
            OP2_EX = ALU_DATA_WB;
    end

    rv_branch_unit #(.XLEN(XLEN)) u_branch (
        .valid     (VALID_EX),
        .opcode    (OPCODE_EX),
        .funct3    (FUNCT3_EX),
        .pc        (PC_EX),
        .imm       (IMM_EX),
        .op1       (OP1_EX),
        .op2       (OP2_EX),
        .taken     (PCSrc),
        .pc_branch (PC_Branch)
    );

    // Squash owns both wrong-path slots; a hazard seen during them is irrelevant.
    assign squash_active = PCSrc || squash_pend_reg;
    assign load_use = !squash_active && VALID_EX && OPCODE_EX == OP_LOAD && RD_EX != 5'd0 &&
                      (RD_EX == RS1_ID || (reads_rs2(OPCODE_ID) && RD_EX == RS2_ID));
    assign bubble      = squash_active || load_use;
    assign PC_write    = !load_use;
    assign IF_ID_write = !load_use;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC_EX           <= '0;
            IMM_EX          <= '0;
            data1_reg       <= '0;
            data2_reg       <= '0;
            FUNCT3_EX       <= '0;
            FUNCT7_EX       <= '0;
            OPCODE_EX       <= BUBBLE_OPCODE;
            RD_EX           <= BUBBLE_RD;
            RS1_EX          <= '0;
            RS2_EX          <= '0;
            VALID_EX        <= 1'b0;
            squash_pend_reg <= 1'b0;
            STALL_COUNT     <= '0;
            SQUASH_COUNT    <= '0;
        end else begin
            squash_pend_reg <= PCSrc;
            if (bubble) begin
                PC_EX     <= '0;
                IMM_EX    <= '0;
                data1_reg <= '0;
                data2_reg <= '0;
                FUNCT3_EX <= '0;
                FUNCT7_EX <= '0;
                OPCODE_EX <= BUBBLE_OPCODE;
                RD_EX     <= BUBBLE_RD;
                RS1_EX    <= '0;
                RS2_EX    <= '0;
                VALID_EX  <= 1'b0;
            end else begin
                PC_EX     <= PC_ID;
                IMM_EX    <= IMM_ID;
                data1_reg <= REG_DATA1_ID;
                data2_reg <= REG_DATA2_ID;
                FUNCT3_EX <= FUNCT3_ID;
                FUNCT7_EX <= FUNCT7_ID;
                OPCODE_EX <= OPCODE_ID;
                RD_EX     <= RD_ID;
                RS1_EX    <= RS1_ID;
                RS2_EX    <= RS2_ID;
                VALID_EX  <= 1'b1;
            end
            if (squash_active && SQUASH_COUNT != '1)
                SQUASH_COUNT <= SQUASH_COUNT + 1'b1;
            if (load_use && STALL_COUNT != '1)
                STALL_COUNT <= STALL_COUNT + 1'b1;
        end
    end

endmodule
